seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div_pkg.sv | 16 +
 rtl/seq_div.sv | 196 +++++++++++++++++++
 tb/tb_seq_div.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider (seq_div).
package seq_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    // Quotient returned for a zero divisor; sliced down to WIDTH (WIDTH <= 64).
    localparam logic [63:0] DZ_QUOTIENT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per cycle, fixed WIDTH+2 latency.
// Macro SEQ_DIV_SIGNED_EN selects two's-complement operands; default build is unsigned.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               bz_q, bz_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH:0]     rem_shift_s;
    logic [WIDTH:0]     diff_s;
`ifdef SEQ_DIV_SIGNED_EN
    logic               quo_neg_q, quo_neg_d;
    logic               rem_neg_q, rem_neg_d;
`endif

    // FSM state and status-flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: done pulses the cycle after DONE, once q/r/dz are already stable
    always_comb begin
        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d = (state_q == ST_DONE);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            a_q       <= '0;
            bz_q      <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            dz_q      <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            a_q       <= a_d;
            bz_q      <= bz_d;
            q_q       <= q_d;
            r_q       <= r_d;
            dz_q      <= dz_d;
`ifdef SEQ_DIV_SIGNED_EN
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    // Datapath: operand capture, restoring step, sign/zero fix-up
    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        a_d       = a_q;
        bz_d      = bz_q;
        q_d       = q_q;
        r_d       = r_q;
        dz_d      = dz_q;
`ifdef SEQ_DIV_SIGNED_EN
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
`endif
        // Guard bit on the shifted remainder: diff_s[WIDTH] set means "restore".
        rem_shift_s = {rem_q, quo_q[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d   = a;
                    bz_d  = (b == '0);
                    cnt_d = '0;
                    rem_d = '0;
`ifdef SEQ_DIV_SIGNED_EN
                    quo_d     = a[WIDTH-1] ? (-a) : a;
                    dvs_d     = b[WIDTH-1] ? (-b) : b;
                    quo_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                    rem_neg_d = a[WIDTH-1];
`else
                    quo_d = a;
                    dvs_d = b;
`endif
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                quo_d = {quo_q[WIDTH-2:0], ~diff_s[WIDTH]};
                if (diff_s[WIDTH]) begin
                    rem_d = rem_shift_s[WIDTH-1:0];
                end else begin
                    rem_d = diff_s[WIDTH-1:0];
                end
            end
            ST_FIX: begin
                if (bz_q) begin
                    q_d  = DZ_QUOTIENT[WIDTH-1:0];
                    r_d  = a_q;
                    dz_d = 1'b1;
                end else begin
`ifdef SEQ_DIV_SIGNED_EN
                    q_d = quo_neg_q ? (-quo_q) : quo_q;
                    r_d = rem_neg_q ? (-rem_q) : rem_q;
`else
                    q_d = quo_q;
                    r_d = rem_q;
`endif
                    dz_d = 1'b0;
                end
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH=32); honours SEQ_DIV_SIGNED_EN.
module tb_seq_div;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [W-1:0] q_o;
    logic [W-1:0] r_o;
    logic         busy_o;
    logic         done_o;
    logic         dz_o;

    int tests_run;
    int fail_cnt;

    seq_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .q     (q_o),
        .r     (r_o),
        .busy  (busy_o),
        .done  (done_o),
        .dz    (dz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_div(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int cyc;
        @(negedge clk);
        a_i   = av;
        b_i   = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests_run++;
        if (busy_o !== 1'b1) begin
            fail_cnt++;
            $display("FAIL %s busy: got %b expected 1", name, busy_o);
        end
        cyc = 0;
        while (done_o !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        tests_run++;
        if (cyc !== LAT) begin
            fail_cnt++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, LAT);
        end
        tests_run++;
        if (q_o !== eq || r_o !== er || dz_o !== edz) begin
            fail_cnt++;
            $display("FAIL %s result: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                     name, q_o, r_o, dz_o, eq, er, edz);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        #12;
        tests_run++;
        if (q_o !== 32'd0 || r_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || dz_o !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dz=%b expected all zero",
                     q_o, r_o, busy_o, done_o, dz_o);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            fail_cnt++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_unsigned();
`ifdef SEQ_DIV_SIGNED_EN
        run_div("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("small_by_big", 32'd5, 32'd10, 32'd0, 32'd5, 1'b0);
        run_div("exact", 32'd144, 32'd12, 32'd12, 32'd0, 1'b0);
`else
        run_div("100_div_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("max_div_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_div("small_by_big", 32'd5, 32'd10, 32'd0, 32'd5, 1'b0);
        run_div("max_div_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_div("msb_div_allones", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_div("max_div_3", 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0, 1'b0);
`endif
    endtask

    task automatic test_signed();
`ifdef SEQ_DIV_SIGNED_EN
        run_div("neg_pos", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_div("pos_neg", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
        run_div("neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
        run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_div("neg_div_zero", 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
`endif
    endtask

    task automatic test_div_zero();
        run_div("div_zero", 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_div("dz_clears", 32'd9, 32'd2, 32'd4, 32'd1, 1'b0);
    endtask

    task automatic test_protocol();
        int done_seen;
        int done_at;
        logic stable_ok;
        @(negedge clk);
        a_i   = 32'd1000;
        b_i   = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        done_seen = 0;
        done_at   = 0;
        stable_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            // Extra starts mid-CALC and during the DONE state; operands keep changing.
            start = (c == 5 || c == 20 || c == LAT);
            a_i   = 32'd50 + 32'(c);
            b_i   = 32'd3;
            @(posedge clk);
            #1;
            if (done_o === 1'b1) begin
                done_seen++;
                done_at = c;
            end
            if (c == 5) begin
                tests_run++;
                if (busy_o !== 1'b1) begin
                    fail_cnt++;
                    $display("FAIL proto_busy_mid: got %b expected 1", busy_o);
                end
            end
            if (c > LAT && (q_o !== 32'd111 || r_o !== 32'd1)) stable_ok = 1'b0;
        end
        start = 1'b0;
        tests_run++;
        if (done_seen !== 1 || done_at !== LAT) begin
            fail_cnt++;
            $display("FAIL proto_single_done: got count=%0d at=%0d expected 1 at %0d", done_seen, done_at, LAT);
        end
        tests_run++;
        if (q_o !== 32'd111 || r_o !== 32'd1) begin
            fail_cnt++;
            $display("FAIL proto_result: got q=%h r=%h expected q=%h r=%h", q_o, r_o, 32'd111, 32'd1);
        end
        tests_run++;
        if (stable_ok !== 1'b1 || busy_o !== 1'b0) begin
            fail_cnt++;
            $display("FAIL proto_hold: got stable=%b busy=%b expected 1 0", stable_ok, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_i   = 32'd777;
        b_i   = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (q_o !== 32'd0 || r_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0 || dz_o !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_mid: got q=%h r=%h busy=%b done=%b dz=%b expected all zero",
                     q_o, r_o, busy_o, done_o, dz_o);
        end
        @(negedge clk);
        reset = 1'b0;
        run_div("after_reset", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_div("b2b_first", 32'd65535, 32'd256, 32'd255, 32'd255, 1'b0);
        run_div("b2b_second", 32'd17, 32'd17, 32'd1, 32'd0, 1'b0);
    endtask

    initial begin
        tests_run = 0;
        fail_cnt  = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_protocol();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
